// File: rtl/puf_eval_controller.sv
// puf_eval_controller
//   Fabric-side sequencer for one PUF evaluation run. A debounced start key press launches
//   NUM_CHAL challenges derived from the DIP-switch seed. Each challenge waits for the PUF's
//   done strobe, with a timeout. The response bits are collected and shown on the LEDs.
//
// Ports
//   clk_clk        in   system clock
//   reset_reset_n  in   asynchronous active-low reset
//   key_n[3:0]     in   raw push buttons, active low; [0]=start, [1]=abort, [3:2] unused
//   dipsw[3:0]     in   challenge seed
//   puf_start      out  one-cycle strobe to evaluate puf_challenge
//   puf_challenge  out  challenge, held from issue through the end of the wait
//   puf_done       in   one-cycle strobe from the PUF core, response valid
//   puf_resp       in   response bit, used only with puf_done while waiting
//   busy           out  run in progress
//   resp_valid     out  run finished, response holds the result
//   response       out  collected bits, bit i = response to challenge i
//   led[7:0]       out  status display
//   stm_hwevents   out  trace pulses: [0] start, [1] puf_start, [2] done, [3] timeout, [4] abort
module puf_eval_controller #(
  parameter int unsigned CW         = 8,
  parameter int unsigned NUM_CHAL   = 8,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [3:0]          key_n,
  input  logic [3:0]          dipsw,
  output logic                puf_start,
  output logic [CW-1:0]       puf_challenge,
  input  logic                puf_done,
  input  logic                puf_resp,
  output logic                busy,
  output logic                resp_valid,
  output logic [NUM_CHAL-1:0] response,
  output logic [7:0]          led,
  output logic [27:0]         stm_hwevents
);

  localparam int unsigned DebW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DebW-1:0] DebCntMax = DebW'(DEB_CYCLES - 1);
  localparam logic [TmrW-1:0] TmrMax    = TmrW'(TIMEOUT - 1);
  localparam logic [2:0]      IdxLast   = 3'(NUM_CHAL - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StNext, StDone} state_t;

  // Debouncers for start (0) and abort (1)
  logic [1:0]      r_sync1, r_sync2, r_lvl, r_press;
  logic [DebW-1:0] r_cnt [2];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_sync1  <= 2'b11;
      r_sync2  <= 2'b11;
      r_lvl    <= 2'b11;
      r_press  <= 2'b00;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      r_sync1 <= key_n[1:0];
      r_sync2 <= r_sync1;
      for (int k = 0; k < 2; k++) begin
        r_press[k] <= 1'b0;
        if (r_sync2[k] == r_lvl[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == DebCntMax) begin
          // DEB_CYCLES consecutive samples at the new level: accept it
          r_cnt[k]   <= '0;
          r_lvl[k]   <= r_sync2[k];
          r_press[k] <= ~r_sync2[k];
        end else begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  logic w_start_ev, w_abort_ev;
  assign w_start_ev = r_press[0];
  assign w_abort_ev = r_press[1];

  logic w_unused_keys;
  assign w_unused_keys = ^key_n[3:2];

  // Sequencer
  state_t              r_state;
  logic [2:0]          r_idx;
  logic [TmrW-1:0]     r_timer;
  logic                r_tflag;
  logic [CW-1:0]       r_base, r_chal;
  logic [NUM_CHAL-1:0] r_resp;
  logic                r_start, r_busy, r_valid;
  logic [7:0]          r_led;
  logic [4:0]          r_stm;

  logic [CW-1:0] w_base;
  logic [2:0]    w_idx_inc;
  logic [7:0]    w_resp_led;

  assign w_base    = CW'(dipsw) << (CW - 4);
  assign w_idx_inc = r_idx + 3'd1;

  always_comb begin
    w_resp_led = '0;
    w_resp_led[NUM_CHAL-1:0] = r_resp;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_timer <= '0;
      r_tflag <= 1'b0;
      r_base  <= '0;
      r_chal  <= '0;
      r_resp  <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_led   <= '0;
      r_stm   <= '0;
    end else begin
      r_start <= 1'b0;
      r_stm   <= '0;
      if (r_busy && w_abort_ev) begin
        // Abort outranks everything, including a same-cycle start or timeout
        r_state  <= StIdle;
        r_idx    <= '0;
        r_resp   <= '0;
        r_tflag  <= 1'b0;
        r_busy   <= 1'b0;
        r_led    <= 8'h00;
        r_stm[4] <= 1'b1;
      end else begin
        case (r_state)
          StIdle, StDone: begin
            if (w_start_ev) begin
              r_state    <= StIssue;
              r_base     <= w_base;
              r_chal     <= w_base;
              r_idx      <= '0;
              r_resp     <= '0;
              r_tflag    <= 1'b0;
              r_start    <= 1'b1;
              r_busy     <= 1'b1;
              r_valid    <= 1'b0;
              r_led      <= 8'h80;
              r_stm[1:0] <= 2'b11;
            end
          end
          StIssue: begin
            r_state <= StWait;
            r_timer <= '0;
          end
          StWait: begin
            if (puf_done) begin
              r_resp[r_idx] <= puf_resp;
              r_state       <= StNext;
            end else if (r_timer == TmrMax) begin
              r_resp[r_idx] <= 1'b0;
              r_tflag       <= 1'b1;
              r_led[6]      <= 1'b1;
              r_stm[3]      <= 1'b1;
              r_state       <= StNext;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          StNext: begin
            if (r_idx == IdxLast) begin
              r_state  <= StDone;
              r_busy   <= 1'b0;
              r_valid  <= 1'b1;
              r_led    <= w_resp_led;
              r_stm[2] <= 1'b1;
            end else begin
              r_state  <= StIssue;
              r_idx    <= w_idx_inc;
              r_chal   <= r_base + CW'(w_idx_inc);
              r_start  <= 1'b1;
              r_led    <= {1'b1, r_tflag, 3'b000, w_idx_inc};
              r_stm[1] <= 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign puf_start     = r_start;
  assign puf_challenge = r_chal;
  assign busy          = r_busy;
  assign resp_valid    = r_valid;
  assign response      = r_resp;
  assign led           = r_led;
  assign stm_hwevents  = {23'd0, r_stm};

endmodule

// File: tb/tb_puf_eval_controller.sv
// tb_puf_eval_controller
//   Directed bench for puf_eval_controller with a cycle model of the run behaviour and a
//   PUF responder whose answer delay, response rule and silent challenge are configurable.
module tb_puf_eval_controller;

  localparam int unsigned CW  = 8;
  localparam int unsigned NC  = 8;
  localparam int unsigned DEB = 16;
  localparam int unsigned TMO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [3:0]    key_n = 4'hF;
  logic [3:0]    dipsw = 4'h0;
  logic          puf_done = 1'b0;
  logic          puf_resp = 1'b0;
  logic          puf_start;
  logic [CW-1:0] puf_challenge;
  logic          busy, resp_valid;
  logic [NC-1:0] response;
  logic [7:0]    led;
  logic [27:0]   stm_hwevents;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  // Responder configuration
  int rsp_delay = 3;
  int rsp_skip = -1;
  bit rsp_const1 = 1'b0;

  logic [CW-1:0] issued[$];
  int n_tmo = 0;
  int n_abort = 0;

  puf_eval_controller #(
    .CW        (CW),
    .NUM_CHAL  (NC),
    .DEB_CYCLES(DEB),
    .TIMEOUT   (TMO)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .key_n        (key_n),
    .dipsw        (dipsw),
    .puf_start    (puf_start),
    .puf_challenge(puf_challenge),
    .puf_done     (puf_done),
    .puf_resp     (puf_resp),
    .busy         (busy),
    .resp_valid   (resp_valid),
    .response     (response),
    .led          (led),
    .stm_hwevents (stm_hwevents)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [1:0]    m_acc = 2'b11;
  int            m_run[2] = '{0, 0};
  bit [2:0]      m_ps = 3'b000;
  bit [2:0]      m_pa = 3'b000;
  bit            m_st, m_ab;
  bit            m_busy = 1'b0;
  bit            m_valid = 1'b0;
  bit            m_tflag = 1'b0;
  bit            m_start = 1'b0;
  int            m_phase = 0;    // 0 issue, 1 waiting, 2 advancing
  int            m_idx = 0;
  int            m_waited = 0;
  logic [7:0]    m_resp = '0;
  logic [CW-1:0] m_base = '0;
  logic [CW-1:0] m_chal = '0;
  logic [4:0]    m_stm = '0;

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_acc = 2'b11; m_run[0] = 0; m_run[1] = 0; m_ps = '0; m_pa = '0;
        m_busy = 0; m_valid = 0; m_tflag = 0; m_start = 0; m_phase = 0; m_idx = 0;
        m_waited = 0; m_resp = '0; m_base = '0; m_chal = '0; m_stm = '0;
      end else begin
        // A press counts once DEB raw samples differ from the accepted level; the
        // synchronizer and event register put the reaction 3 edges later.
        m_st = m_ps[2];
        m_ab = m_pa[2];
        m_ps = {m_ps[1:0], 1'b0};
        m_pa = {m_pa[1:0], 1'b0};
        for (int k = 0; k < 2; k++) begin
          if (key_n[k] != m_acc[k]) begin
            m_run[k]++;
            if (m_run[k] == DEB) begin
              m_acc[k] = key_n[k];
              m_run[k] = 0;
              if (!key_n[k]) begin
                if (k == 0) m_ps[0] = 1'b1;
                else m_pa[0] = 1'b1;
              end
            end
          end else begin
            m_run[k] = 0;
          end
        end
        m_start = 0;
        m_stm = '0;
        if (m_busy && m_ab) begin
          m_busy = 0; m_idx = 0; m_resp = '0; m_tflag = 0; m_stm[4] = 1;
        end else if (!m_busy && m_st) begin
          m_base = CW'(dipsw) * (2 ** (CW - 4));
          m_idx = 0; m_resp = '0; m_tflag = 0; m_busy = 1; m_valid = 0; m_phase = 0;
          m_chal = m_base; m_start = 1; m_stm[0] = 1; m_stm[1] = 1;
        end else if (m_busy) begin
          if (m_phase == 0) begin
            m_phase = 1;
            m_waited = 0;
          end else if (m_phase == 1) begin
            m_waited++;
            if (puf_done) begin
              m_resp[m_idx] = puf_resp;
              m_phase = 2;
            end else if (m_waited == TMO) begin
              m_resp[m_idx] = 1'b0;
              m_tflag = 1;
              m_stm[3] = 1;
              m_phase = 2;
            end
          end else if (m_idx == NC - 1) begin
            m_busy = 0; m_valid = 1; m_stm[2] = 1;
          end else begin
            m_idx++;
            m_chal = m_base + CW'(m_idx);
            m_phase = 0; m_start = 1; m_stm[1] = 1;
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin : compare
    logic [7:0] eled;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        if (puf_start) issued.push_back(puf_challenge);
        if (stm_hwevents[3]) n_tmo++;
        if (stm_hwevents[4]) n_abort++;
        if (m_busy) eled = {1'b1, m_tflag, 3'b000, 3'(m_idx)};
        else if (m_valid) eled = m_resp;
        else eled = 8'h00;
        check("busy", 32'(busy), 32'(m_busy));
        check("resp_valid", 32'(resp_valid), 32'(m_valid));
        check("response", 32'(response), 32'(m_resp));
        check("led", 32'(led), 32'(eled));
        check("puf_start", 32'(puf_start), 32'(m_start));
        check("stm", 32'(stm_hwevents), {27'd0, m_stm});
        if (m_busy) check("challenge", 32'(puf_challenge), 32'(m_chal));
      end
    end
  end

  // ---------------- PUF responder ----------------
  initial begin : responder
    int pend;
    logic [CW-1:0] held;
    pend = 0;
    held = '0;
    forever begin
      @(negedge clk);
      puf_done = 1'b0;
      puf_resp = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          puf_done = 1'b1;
          puf_resp = rsp_const1 ? 1'b1 : held[0];
        end
      end
      if (puf_start && rsp_skip != int'(puf_challenge[2:0])) begin
        pend = rsp_delay;
        held = puf_challenge;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic press(input logic [1:0] mask, input int n);
    @(negedge clk);
    key_n[1:0] = ~mask;
    repeat (n) @(negedge clk);
    key_n[1:0] = 2'b11;
  endtask

  function automatic bit sig_ok(input int sel);
    case (sel)
      0: return stm_hwevents[0];
      1: return resp_valid;
      default: return !busy;
    endcase
  endfunction

  task automatic wait_sig(input string what, input int sel, input int budget);
    int n = 0;
    while (!sig_ok(sel) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_%s: waited %0d cycles, required within %0d", what, n, budget);
    end
  endtask

  task automatic wait_idx(input int idx, output int at);
    int n = 0;
    while (!(puf_start && int'(puf_challenge[2:0]) == idx) && n < 500) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL wait_idx%0d: waited %0d cycles, required puf_start within 500", idx, n);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin : main
    int t_a, t_b, n0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_stm", 32'(stm_hwevents), 32'd0);
    check("rst_chal", 32'(puf_challenge), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // T1: reset in the middle of a wait; the late done must not write anything
    dipsw = 4'h3; rsp_delay = 3; rsp_skip = -1; rsp_const1 = 1'b0;
    press(2'b01, 20);
    wait_idx(1, t_a);
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_start", 32'(puf_start), 32'd0);
    check("t1_resp", 32'(response), 32'd0);
    check("t1_led", 32'(led), 32'd0);
    check("t1_chal", 32'(puf_challenge), 32'd0);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("t1_late_resp", 32'(response), 32'd0);
    check("t1_late_valid", 32'(resp_valid), 32'd0);
    repeat (40) @(negedge clk);

    // T2: seed A, answer 3 cycles after each start with resp = idx[0]
    dipsw = 4'hA; issued.delete();
    press(2'b01, 20);
    wait_sig("t2_valid", 1, 300);
    check("t2_count", 32'(issued.size()), 32'd8);
    for (int i = 0; i < NC; i++)
      check($sformatf("t2_chal%0d", i), (i < issued.size()) ? 32'(issued[i]) : 32'hx,
            32'h0000_00A0 + 32'(i));
    check("t2_response", 32'(response), 32'h0000_00AA);
    check("t2_led", 32'(led), 32'h0000_00AA);
    repeat (40) @(negedge clk);

    // T3: a DEB-1 glitch is ignored; a DEB press gives exactly one run
    issued.delete(); rsp_delay = 1;
    press(2'b01, DEB - 1);
    repeat (60) @(negedge clk);
    check("t3_glitch_starts", 32'(issued.size()), 32'd0);
    press(2'b01, DEB);
    wait_sig("t3_stm0", 0, 20);
    t_a = cyc;
    wait_sig("t3_valid", 1, 100);
    t_b = cyc;
    check("t3_runlen", 32'(t_b - t_a), 32'(3 * NC));
    repeat (60) @(negedge clk);
    check("t3_one_run", 32'(issued.size()), 32'd8);

    // T4: challenge 2 is never answered
    dipsw = 4'h5; rsp_delay = 2; rsp_const1 = 1'b1; rsp_skip = 2; n0 = n_tmo;
    press(2'b01, 20);
    wait_idx(2, t_a);
    @(negedge clk);
    wait_idx(3, t_b);
    check("t4_gap", 32'(t_b - t_a), 32'(TMO + 2));
    check("t4_led_busy", 32'(led), 32'h0000_00C3);
    wait_sig("t4_valid", 1, 200);
    check("t4_response", 32'(response), 32'h0000_00FB);
    check("t4_tmo_pulses", 32'(n_tmo - n0), 32'd1);
    repeat (40) @(negedge clk);

    // T5: abort during the wait of idx 5
    dipsw = 4'hC; rsp_const1 = 1'b0; rsp_skip = 5; n0 = n_abort; issued.delete();
    press(2'b01, 20);
    wait_idx(5, t_a);
    press(2'b10, 20);
    wait_sig("t5_idle", 2, 200);
    check("t5_response", 32'(response), 32'd0);
    check("t5_led", 32'(led), 32'd0);
    check("t5_valid", 32'(resp_valid), 32'd0);
    check("t5_abort_pulses", 32'(n_abort - n0), 32'd1);
    check("t5_starts", 32'(issued.size()), 32'd6);
    repeat (80) @(negedge clk);
    check("t5_no_more", 32'(issued.size()), 32'd6);

    // T6a: start and abort accepted together while busy
    dipsw = 4'h1; rsp_skip = 3; n0 = n_abort; issued.delete();
    press(2'b01, 20);
    wait_idx(3, t_a);
    repeat (30) @(negedge clk);
    press(2'b11, 20);
    wait_sig("t6a_idle", 2, 200);
    check("t6a_response", 32'(response), 32'd0);
    check("t6a_abort_pulses", 32'(n_abort - n0), 32'd1);
    repeat (60) @(negedge clk);
    check("t6a_starts", 32'(issued.size()), 32'd4);
    check("t6a_valid", 32'(resp_valid), 32'd0);

    // T6b: a second start press during a run is ignored
    dipsw = 4'h9; rsp_skip = -1; rsp_delay = 6; issued.delete();
    press(2'b01, 20);
    repeat (25) @(negedge clk);
    press(2'b01, 20);
    wait_sig("t6b_valid", 1, 300);
    repeat (40) @(negedge clk);
    check("t6b_count", 32'(issued.size()), 32'd8);
    for (int i = 0; i < NC; i++)
      check($sformatf("t6b_chal%0d", i), (i < issued.size()) ? 32'(issued[i]) : 32'hx,
            32'h0000_0090 + 32'(i));
    check("t6b_response", 32'(response), 32'h0000_00AA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
